key_scheduler: RTL and testbench

KEY_SCHEDULER -- requirements
Module: key_scheduler

---
 rtl/key_scheduler.sv | 162 ++++++++++++++++
 tb/tb_key_scheduler.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_scheduler.sv
// key_scheduler: hands out RC4 candidate keys to a pool of cracking cores.
// Keys are issued in ascending order, one grant per cycle at most, with a
// round-robin search over requesting cores. The first reported hit ends the
// search (FOUND). Running past the last key ends it too: the last key is
// issued, the scheduler drains, and it reports FAILED once every core is idle.
module key_scheduler #(
   parameter int                    CORE_NUMBER            = 4,
   parameter int                    KEY_WIDTH              = 24,
   parameter logic [KEY_WIDTH-1:0]  MAX_SIZE_OF_SECRET_KEY = 24'h3FFFFF,
   localparam int                   IDX_W = (CORE_NUMBER > 1) ? $clog2(CORE_NUMBER) : 1
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             start,
   input  logic [CORE_NUMBER-1:0]           key_req,
   input  logic [CORE_NUMBER-1:0]           core_busy,
   input  logic [CORE_NUMBER-1:0]           hit,
   input  logic [CORE_NUMBER*KEY_WIDTH-1:0] hit_key,
   output logic [CORE_NUMBER-1:0]           key_grant,
   output logic [KEY_WIDTH-1:0]             key_out,
   output logic                             stop,
   output logic                             running,
   output logic                             found,
   output logic                             failed,
   output logic [KEY_WIDTH-1:0]             found_key,
   output logic [IDX_W-1:0]                 found_core
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN,
      S_FOUND,
      S_FAILED
   } state_t;

   // One extra bit so that issuing the all-ones key cannot wrap back to zero.
   localparam logic [KEY_WIDTH:0] LP_LAST_KEY = {1'b0, MAX_SIZE_OF_SECRET_KEY};

   state_t                 r_state;
   logic [KEY_WIDTH:0]     r_next_key;
   logic [IDX_W-1:0]       r_rr_ptr;

   logic [CORE_NUMBER-1:0] w_eligible;
   logic                   w_grant_valid;
   logic [IDX_W-1:0]       w_grant_idx;
   logic [IDX_W-1:0]       w_scan_idx;
   logic [CORE_NUMBER-1:0] w_grant_onehot;
   logic [IDX_W-1:0]       w_rr_next;
   logic                   w_issue;
   logic                   w_hit_any;
   logic [IDX_W-1:0]       w_hit_idx;
   logic [KEY_WIDTH-1:0]   w_hit_key;

   // A core granted last cycle has not yet seen its grant, so it sits out one cycle.
   assign w_eligible = key_req & ~key_grant;

   // Round-robin search: first eligible core at or above rr_ptr, wrapping around.
   always_comb begin
      w_grant_valid = 1'b0;
      w_grant_idx   = '0;
      w_scan_idx    = '0;
      for (int unsigned k = 0; k < CORE_NUMBER; k++) begin
         w_scan_idx = IDX_W'((32'(r_rr_ptr) + k) % CORE_NUMBER);
         if (!w_grant_valid && w_eligible[w_scan_idx]) begin
            w_grant_valid = 1'b1;
            w_grant_idx   = w_scan_idx;
         end
      end
   end

   // Decode the chosen core into the one-hot grant pattern.
   always_comb begin
      w_grant_onehot = '0;
      for (int unsigned k = 0; k < CORE_NUMBER; k++) begin
         w_grant_onehot[k] = w_grant_valid && (w_grant_idx == IDX_W'(k));
      end
   end

   assign w_rr_next = (w_grant_idx == IDX_W'(CORE_NUMBER - 1)) ? '0 : w_grant_idx + 1'b1;

   // Never issue a key beyond the last one, even if a request is pending.
   assign w_issue = w_grant_valid && (r_next_key <= LP_LAST_KEY);

   // Lowest-numbered hitting core wins when several report in the same cycle.
   always_comb begin
      w_hit_idx = '0;
      for (int k = CORE_NUMBER - 1; k >= 0; k--) begin
         if (hit[k]) begin
            w_hit_idx = IDX_W'(k);
         end
      end
   end

   assign w_hit_any = |hit;
   assign w_hit_key = hit_key[w_hit_idx*KEY_WIDTH +: KEY_WIDTH];

   // Control FSM with all outputs registered alongside the state.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_next_key <= '0;
         r_rr_ptr   <= '0;
         key_grant  <= '0;
         key_out    <= '0;
         stop       <= 1'b0;
         running    <= 1'b0;
         found      <= 1'b0;
         failed     <= 1'b0;
         found_key  <= '0;
         found_core <= '0;
      end else begin
         key_grant <= '0;
         unique case (r_state)
            S_IDLE, S_FOUND, S_FAILED: begin
               if (start) begin
                  r_state    <= S_RUN;
                  r_next_key <= '0;
                  r_rr_ptr   <= '0;
                  stop       <= 1'b0;
                  running    <= 1'b1;
                  found      <= 1'b0;
                  failed     <= 1'b0;
                  found_key  <= '0;
                  found_core <= '0;
               end
            end
            S_RUN, S_DRAIN: begin
               if (w_hit_any) begin
                  r_state    <= S_FOUND;
                  found      <= 1'b1;
                  found_core <= w_hit_idx;
                  found_key  <= w_hit_key;
                  stop       <= 1'b1;
                  running    <= 1'b0;
               end else if (r_state == S_RUN) begin
                  if (w_issue) begin
                     key_grant  <= w_grant_onehot;
                     key_out    <= r_next_key[KEY_WIDTH-1:0];
                     r_next_key <= r_next_key + 1'b1;
                     r_rr_ptr   <= w_rr_next;
                     if (r_next_key == LP_LAST_KEY) begin
                        r_state <= S_DRAIN;
                     end
                  end
               end else if (core_busy == '0) begin
                  r_state <= S_FAILED;
                  failed  <= 1'b1;
                  stop    <= 1'b1;
                  running <= 1'b0;
               end
            end
            default: begin
               r_state <= S_IDLE;
               running <= 1'b0;
               stop    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_key_scheduler.sv
// Testbench for key_scheduler: directed scenarios plus a randomized run, all
// checked against a behavioural model of the scheduler kept in this file.
module tb_key_scheduler;

   localparam int CN   = 4;
   localparam int KW   = 24;
   localparam int MAXK = 15;

   localparam int M_IDLE   = 0;
   localparam int M_RUN    = 1;
   localparam int M_DRAIN  = 2;
   localparam int M_FOUND  = 3;
   localparam int M_FAILED = 4;

   logic           clk = 1'b0;
   logic           rst;
   logic           start;
   logic [CN-1:0]  key_req;
   logic [CN-1:0]  core_busy;
   logic [CN-1:0]  hit;
   logic [CN*KW-1:0] hit_key;
   logic [CN-1:0]  key_grant;
   logic [KW-1:0]  key_out;
   logic           stop;
   logic           running;
   logic           found;
   logic           failed;
   logic [KW-1:0]  found_key;
   logic [1:0]     found_core;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state and expected outputs
   int          m_st   = M_IDLE;
   int unsigned m_nk   = 0;
   int          m_rr   = 0;
   int          m_prev = -1;
   logic [CN-1:0] e_grant = '0;
   logic [KW-1:0] e_key   = '0;
   logic        e_stop = 0, e_run = 0, e_found = 0, e_failed = 0;
   logic [KW-1:0] e_fkey  = '0;
   logic [1:0]  e_fcore = '0;

   logic [33:0] obs_v, exp_v;

   key_scheduler #(
      .CORE_NUMBER(CN),
      .KEY_WIDTH(KW),
      .MAX_SIZE_OF_SECRET_KEY(24'h00000F)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .key_req(key_req),
      .core_busy(core_busy), .hit(hit), .hit_key(hit_key),
      .key_grant(key_grant), .key_out(key_out), .stop(stop),
      .running(running), .found(found), .failed(failed),
      .found_key(found_key), .found_core(found_core)
   );

   always #5 clk = ~clk;

   // Scheduler behaviour for one clock edge, from the inputs currently applied.
   function automatic void model_step();
      int g;
      int lo;
      int c;
      g = -1;
      lo = 0;
      if (rst) begin
         m_st = M_IDLE; m_nk = 0; m_rr = 0; m_prev = -1;
         e_grant = '0; e_key = '0; e_stop = 0; e_run = 0;
         e_found = 0; e_failed = 0; e_fkey = '0; e_fcore = '0;
         return;
      end
      e_grant = '0;
      if (m_st == M_IDLE || m_st == M_FOUND || m_st == M_FAILED) begin
         if (start) begin
            m_st = M_RUN; m_nk = 0; m_rr = 0;
            e_found = 0; e_failed = 0; e_fkey = '0; e_fcore = '0;
            e_run = 1; e_stop = 0;
         end
      end else if (hit != 0) begin
         for (int i = CN - 1; i >= 0; i--) if (hit[i]) lo = i;
         e_fcore = 2'(lo);
         e_fkey  = hit_key[lo*KW +: KW];
         e_found = 1; e_stop = 1; e_run = 0;
         m_st = M_FOUND;
      end else if (m_st == M_RUN) begin
         for (int k = 0; k < CN; k++) begin
            c = (m_rr + k) % CN;
            if (g < 0 && key_req[c] && c != m_prev && m_nk <= MAXK) g = c;
         end
         if (g >= 0) begin
            e_grant[g] = 1'b1;
            e_key = KW'(m_nk);
            if (m_nk == MAXK) m_st = M_DRAIN;
            m_nk++;
            m_rr = (g + 1) % CN;
         end
      end else begin
         if (core_busy == 0) begin
            m_st = M_FAILED; e_failed = 1; e_stop = 1; e_run = 0;
         end
      end
      m_prev = g;
   endfunction

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1; start = 1; key_req = '1; core_busy = '1; hit = 4'b0100;
      hit_key = {$urandom, $urandom, $urandom};
      tick(); tick();
      n_checks++; if (key_grant !== 4'b0) begin n_fail++; $display("FAIL reset_grant: got %h expected 0", key_grant); end
      n_checks++; if (key_out !== 24'h0) begin n_fail++; $display("FAIL reset_key_out: got %h expected 0", key_out); end
      n_checks++; if ({stop, running, found, failed} !== 4'b0) begin n_fail++; $display("FAIL reset_flags: got %b expected 0000", {stop, running, found, failed}); end
      n_checks++; if (found_key !== 24'h0) begin n_fail++; $display("FAIL reset_found_key: got %h expected 0", found_key); end
      n_checks++; if (found_core !== 2'd0) begin n_fail++; $display("FAIL reset_found_core: got %0d expected 0", found_core); end
      // idle: requests and hits are ignored
      rst = 0; start = 0; hit = 4'b0001;
      for (int i = 0; i < 3; i++) begin
         tick();
         obs_v = {key_grant, stop, running, found, failed, found_key, found_core};
         exp_v = {e_grant, e_stop, e_run, e_found, e_failed, e_fkey, e_fcore};
         n_checks++;
         if (obs_v !== exp_v) begin n_fail++; $display("FAIL idle_model: got %h expected %h", obs_v, exp_v); end
      end
      n_checks++; if ({found, running, key_grant} !== 6'b0) begin n_fail++; $display("FAIL idle_ignore: got %b expected 0", {found, running, key_grant}); end
      hit = '0;
   endtask

   task automatic test_exhaust();
      int n_iss;
      int drain;
      n_iss = 0; drain = 0;
      key_req = '1; core_busy = 4'b0010; start = 1;
      tick();
      start = 0;
      for (int cyc = 0; cyc < 60 && !failed; cyc++) begin
         tick();
         obs_v = {key_grant, stop, running, found, failed, found_key, found_core};
         exp_v = {e_grant, e_stop, e_run, e_found, e_failed, e_fkey, e_fcore};
         n_checks++;
         if (obs_v !== exp_v) begin n_fail++; $display("FAIL exhaust_model: got %h expected %h", obs_v, exp_v); end
         if (e_grant != 0) begin
            n_checks++;
            if (key_out !== e_key) begin n_fail++; $display("FAIL exhaust_model_key: got %h expected %h", key_out, e_key); end
         end
         if (key_grant != 0) begin
            n_checks++;
            if (key_out !== KW'(n_iss) || key_grant !== 4'(1 << (n_iss % CN))) begin
               n_fail++;
               $display("FAIL exhaust_order: got key %h grant %b expected key %h grant %b",
                        key_out, key_grant, n_iss, 4'(1 << (n_iss % CN)));
            end
            n_iss++;
         end
         key_req = ~key_grant;
         if (n_iss >= MAXK + 1) begin
            key_req = '0;
            drain++;
            core_busy = (drain > 3) ? 4'b0000 : 4'b0010;
         end
      end
      n_checks++; if (n_iss !== MAXK + 1) begin n_fail++; $display("FAIL exhaust_count: got %0d expected %0d", n_iss, MAXK + 1); end
      n_checks++; if ({failed, stop, running, found} !== 4'b1100) begin n_fail++; $display("FAIL exhaust_final: got %b expected 1100", {failed, stop, running, found}); end
      n_checks++; if (drain !== 5) begin n_fail++; $display("FAIL exhaust_drain_len: got %0d expected 5", drain); end
   endtask

   task automatic test_hit();
      key_req = '1; core_busy = '1; start = 1; hit = '0;
      tick();
      start = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         obs_v = {key_grant, stop, running, found, failed, found_key, found_core};
         exp_v = {e_grant, e_stop, e_run, e_found, e_failed, e_fkey, e_fcore};
         n_checks++;
         if (obs_v !== exp_v) begin n_fail++; $display("FAIL hit_model: got %h expected %h", obs_v, exp_v); end
         key_req = ~key_grant;
      end
      key_req = '1;
      hit = 4'b0100;
      hit_key = {$urandom, $urandom, $urandom};
      hit_key[2*KW +: KW] = 24'h00A5C3;
      tick();
      n_checks++; if (key_grant !== 4'b0) begin n_fail++; $display("FAIL hit_no_grant: got %b expected 0000", key_grant); end
      n_checks++; if ({found, stop, running} !== 3'b110) begin n_fail++; $display("FAIL hit_flags: got %b expected 110", {found, stop, running}); end
      n_checks++; if (found_core !== 2'd2 || found_key !== 24'h00A5C3) begin n_fail++; $display("FAIL hit_capture: got core %0d key %h expected core 2 key 00a5c3", found_core, found_key); end
      // found is sticky and later hits do not overwrite it
      hit = 4'b0001;
      hit_key = {$urandom, $urandom, $urandom};
      tick(); tick();
      n_checks++; if (found_core !== 2'd2 || found_key !== 24'h00A5C3 || !found) begin n_fail++; $display("FAIL hit_sticky: got core %0d key %h expected core 2 key 00a5c3", found_core, found_key); end
      hit = '0;
   endtask

   task automatic test_multi_hit();
      logic [KW-1:0] want;
      start = 1; key_req = '1;
      tick();
      start = 0;
      n_checks++; if ({found, running, stop} !== 3'b010) begin n_fail++; $display("FAIL restart_clear: got %b expected 010", {found, running, stop}); end
      tick(); tick();
      hit = 4'b1010;
      hit_key = {$urandom, $urandom, $urandom};
      want = hit_key[1*KW +: KW];
      tick();
      n_checks++; if (found_core !== 2'd1 || found_key !== want) begin n_fail++; $display("FAIL multi_hit: got core %0d key %h expected core 1 key %h", found_core, found_key, want); end
      obs_v = {key_grant, stop, running, found, failed, found_key, found_core};
      exp_v = {e_grant, e_stop, e_run, e_found, e_failed, e_fkey, e_fcore};
      n_checks++;
      if (obs_v !== exp_v) begin n_fail++; $display("FAIL multi_hit_model: got %h expected %h", obs_v, exp_v); end
      hit = '0;
   endtask

   task automatic test_single_core();
      logic [CN-1:0] want_g;
      key_req = 4'b0001; start = 1;
      tick();
      start = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         want_g = (i % 2 == 0) ? 4'b0001 : 4'b0000;
         n_checks++;
         if (key_grant !== want_g || (want_g != 0 && key_out !== KW'(i / 2))) begin
            n_fail++;
            $display("FAIL single_core: got grant %b key %h expected grant %b key %h", key_grant, key_out, want_g, i / 2);
         end
         obs_v = {key_grant, stop, running, found, failed, found_key, found_core};
         exp_v = {e_grant, e_stop, e_run, e_found, e_failed, e_fkey, e_fcore};
         n_checks++;
         if (obs_v !== exp_v) begin n_fail++; $display("FAIL single_core_model: got %h expected %h", obs_v, exp_v); end
      end
   endtask

   task automatic test_reset_mid();
      int n_iss;
      bit seen;
      n_iss = 0; seen = 0;
      rst = 1; tick(); rst = 0;
      key_req = '1; start = 1;
      tick();
      start = 0;
      for (int cyc = 0; cyc < 20 && n_iss < 5; cyc++) begin
         tick();
         if (key_grant != 0) n_iss++;
         key_req = ~key_grant;
      end
      n_checks++; if (n_iss !== 5) begin n_fail++; $display("FAIL reset_mid_progress: got %0d expected 5", n_iss); end
      rst = 1; start = 1; key_req = '1;
      tick();
      rst = 0;
      tick();
      start = 0;
      n_checks++; if (running !== 1'b1) begin n_fail++; $display("FAIL reset_mid_run: got %b expected 1", running); end
      for (int cyc = 0; cyc < 10 && !seen; cyc++) begin
         tick();
         if (key_grant != 0) begin
            seen = 1;
            n_checks++;
            if (key_out !== 24'h0 || key_grant !== 4'b0001) begin n_fail++; $display("FAIL reset_mid_first: got key %h grant %b expected key 000000 grant 0001", key_out, key_grant); end
         end
      end
      n_checks++; if (!seen) begin n_fail++; $display("FAIL reset_mid_timeout: got no grant expected grant"); end
   endtask

   task automatic test_drain_hit();
      int n_iss;
      bit seen;
      n_iss = 0; seen = 0;
      rst = 1; tick(); rst = 0;
      key_req = '1; core_busy = 4'b0001; start = 1;
      tick();
      start = 0;
      for (int cyc = 0; cyc < 40 && n_iss < MAXK + 1; cyc++) begin
         tick();
         if (key_grant != 0) n_iss++;
         key_req = ~key_grant;
      end
      key_req = '0;
      tick();
      n_checks++; if ({running, failed, key_grant} !== 6'b100000 || n_iss !== MAXK + 1) begin n_fail++; $display("FAIL drain_wait: got %b issued %0d expected 100000 issued 16", {running, failed, key_grant}, n_iss); end
      hit = 4'b0001;
      hit_key = {$urandom, $urandom, $urandom};
      tick();
      hit = '0;
      n_checks++; if ({found, failed, stop} !== 3'b101 || found_core !== 2'd0) begin n_fail++; $display("FAIL drain_hit: got %b core %0d expected 101 core 0", {found, failed, stop}, found_core); end
      start = 1;
      tick();
      start = 0; key_req = '1;
      n_checks++; if ({found, running} !== 2'b01) begin n_fail++; $display("FAIL drain_restart: got %b expected 01", {found, running}); end
      for (int cyc = 0; cyc < 10 && !seen; cyc++) begin
         tick();
         if (key_grant != 0) begin
            seen = 1;
            n_checks++;
            if (key_out !== 24'h0 || key_grant !== 4'b0001) begin n_fail++; $display("FAIL drain_restart_key: got key %h grant %b expected key 000000 grant 0001", key_out, key_grant); end
         end
      end
      n_checks++; if (!seen) begin n_fail++; $display("FAIL drain_restart_timeout: got no grant expected grant"); end
   endtask

   task automatic test_random();
      for (int cyc = 0; cyc < 600; cyc++) begin
         rst       = ($urandom % 80 == 0);
         start     = ($urandom % 12 == 0);
         key_req   = 4'($urandom);
         core_busy = ($urandom % 3 == 0) ? 4'($urandom) : 4'b0;
         hit       = ($urandom % 25 == 0) ? 4'($urandom) : 4'b0;
         hit_key   = {$urandom, $urandom, $urandom};
         tick();
         obs_v = {key_grant, stop, running, found, failed, found_key, found_core};
         exp_v = {e_grant, e_stop, e_run, e_found, e_failed, e_fkey, e_fcore};
         n_checks++;
         if (obs_v !== exp_v) begin n_fail++; $display("FAIL random_model: got %h expected %h", obs_v, exp_v); end
         if (e_grant != 0) begin
            n_checks++;
            if (key_out !== e_key) begin n_fail++; $display("FAIL random_key: got %h expected %h", key_out, e_key); end
         end
      end
   endtask

   initial begin
      rst = 1; start = 0; key_req = '0; core_busy = '0; hit = '0; hit_key = '0;
      test_reset();
      test_exhaust();
      test_hit();
      test_multi_hit();
      test_single_core();
      test_reset_mid();
      test_drain_hit();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
